// File: rtl/load_store_unit_if.sv
// Request/response and memory-port bundle for the load/store unit.
// slave is the LSU side; master is the core/memory side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [2:0]  mem_funct3;
    logic        mem_wren;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output mem_funct3, mem_wren, mem_address, mem_data_in
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  mem_funct3, mem_wren, mem_address, mem_data_in
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store stage: word-only memory traffic, read-modify-write for sub-word stores,
// load extraction/extension and alignment/funct3 error rejection.
module load_store_unit #(
    parameter int unsigned READ_LATENCY = 1
) (
    input logic               clk,
    input logic               reset,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e      state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [2:0]  lat_cnt_q;
    logic        mem_wren_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_data_in_q;
    logic        rsp_valid_q;
    logic        rsp_error_q;
    logic [31:0] rsp_rdata_q;

    function automatic logic access_error(input logic we, input logic [2:0] f3,
                                          input logic [1:0] lane);
        logic err;
        case (f3)
            3'b000:  err = 1'b0;
            3'b001:  err = lane[0];
            3'b010:  err = (lane != 2'b00);
            3'b100:  err = we;
            3'b101:  err = we | lane[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic is_half, input logic [1:0] lane,
                                                input logic [31:0] word, input logic [15:0] wd);
        logic [31:0] m;
        m = word;
        if (is_half) m[{lane[1], 4'b0000} +: 16] = wd;
        else         m[{lane, 3'b000} +: 8] = wd[7:0];
        return m;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            we_q          <= 1'b0;
            funct3_q      <= 3'b000;
            lane_q        <= 2'b00;
            wdata_q       <= 16'h0;
            lat_cnt_q     <= 3'd0;
            mem_wren_q    <= 1'b0;
            mem_address_q <= 32'h0;
            mem_data_in_q <= 32'h0;
            rsp_valid_q   <= 1'b0;
            rsp_error_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            mem_wren_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        we_q          <= bus.req_we;
                        funct3_q      <= bus.req_funct3;
                        lane_q        <= bus.req_addr[1:0];
                        wdata_q       <= bus.req_wdata[15:0];
                        mem_address_q <= {bus.req_addr[31:2], 2'b00};
                        lat_cnt_q     <= 3'd0;
                        if (access_error(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
                            state_q       <= StWrite;
                            mem_wren_q    <= 1'b1;
                            mem_data_in_q <= bus.req_wdata;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StRead: begin
                    // Memory samples the address one edge after accept, hence the L+1 capture.
                    if (lat_cnt_q == 3'(READ_LATENCY)) begin
                        lat_cnt_q <= 3'd0;
                        if (we_q) begin
                            state_q       <= StWrite;
                            mem_wren_q    <= 1'b1;
                            mem_data_in_q <= store_merge(funct3_q[0], lane_q,
                                                         bus.mem_data_out, wdata_q);
                        end else begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b0;
                            rsp_rdata_q <= load_extract(funct3_q, lane_q, bus.mem_data_out);
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 3'd1;
                    end
                end
                StWrite: begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                    rsp_error_q <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                end
                StResp: begin
                    state_q     <= StIdle;
                    rsp_error_q <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                end
            endcase
        end
    end

    assign bus.req_ready   = (state_q == StIdle);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_error   = rsp_error_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.mem_funct3  = 3'b010;
    assign bus.mem_wren    = mem_wren_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data_in = mem_data_in_q;

endmodule
